nonce_search_ctrl: RTL and testbench
====================================

// Module: nonce_search_ctrl
// PURPOSE
//  Drives the micro_ucr_hash core and checks its result: mining-loop controller.
//  Forms bloque_in = {96-bit header, 32-bit nonce} and pulses fill.
//  Waits the core's fixed latency, then compares H against a target.
//  Increments the nonce until a hit or until MAX_NONCE is exhausted.
// PARAMETERS
//  HASH_LATENCY  20            cycles from the fill pulse to a stable H at the core output (>=1)
//  MAX_NONCE     32'hFFFFFFFF  last nonce tried before reporting exhaustion
// PORTS
//  clk        in   1    single clock, rising edge
//  reset_L    in   1    synchronous, active-low reset
//  start      in   1    1-cycle request; sampled only in IDLE
//  header_in  in   96   block header; latched on an accepted start
//  target     in   8    difficulty byte; latched on an accepted start
//  hash_H     in   24   H output of micro_ucr_hash
//  fill       out  1    1-cycle load/start strobe to micro_ucr_hash
//  bloque_in  out  128  {header_q, nonce}; [127:32]=header, [31:0]=nonce
//  busy       out  1    high in every state except IDLE, FOUND and EXHAUST
//  found      out  1    level; high in FOUND
//  exhausted  out  1    level; high in EXHAUST
//  nonce_out  out  32   winning nonce; valid while found=1
//  H_out      out  24   winning hash; valid while found=1
// BEHAVIOUR
//  Reset (reset_L=0 at a clk edge):
//   - state=IDLE; all outputs 0, including fill and bloque_in.
//   - Reset overrides everything, including mid-search; the search is abandoned, no result.
//  States: IDLE, LOAD, WAIT, CHECK, FOUND, EXHAUST.
//  IDLE:
//   - start=1 latches header_in and target, sets nonce=0, goes to LOAD.
//  LOAD (1 cycle):
//   - fill=1; bloque_in={header_q,nonce}; wait counter loaded with HASH_LATENCY-1; go to WAIT.
//  WAIT:
//   - fill=0; bloque_in held stable.
//   - Counter decrements; at 0, go to CHECK.
//  CHECK (1 cycle), hit test: hash_H[23:16] < target_q AND hash_H[15:8] < target_q (unsigned).
//   - hit: capture nonce_out=nonce, H_out=hash_H; go to FOUND.
//   - miss, nonce==MAX_NONCE: go to EXHAUST; nonce does not wrap.
//   - miss otherwise: nonce=nonce+1; go to LOAD.
//  Cost per nonce = HASH_LATENCY+2 cycles.
//   - The fill for nonce n+1 comes exactly HASH_LATENCY+2 cycles after the fill for n.
//  FOUND / EXHAUST:
//   - Outputs held.
//   - start=1 clears found/exhausted and restarts as from IDLE, same cycle semantics.
//  Busy rules:
//   - start while busy=1 is ignored.
//   - header_in/target changes while busy have no effect.
//  target=0:
//   - No hit is possible; the search runs to EXHAUST.
//  fill is never high for 2 consecutive cycles; fill=1 only in LOAD.
//  hash_H is sampled only in CHECK.
// TESTING
//  The bench uses a hash stub: HASH_LATENCY cycles after fill, H={8'hFF-n[7:0], 8'hFF-n[7:0], 8'h00}.
//  1. Reset: reset_L=0 for 3 cycles -> fill=0, bloque_in=0, busy=found=exhausted=0,
//     nonce_out=H_out=0.
//  2. Hit: header=96'hA5, target=8'h10, start -> found=1, nonce_out=32'hF0,
//     H_out=24'h0F0F00, 241 fill pulses.
//  3. Exhaustion: MAX_NONCE=32'h0F, target=8'h10 -> exhausted=1, found=0, 16 fills,
//     done 16*(HASH_LATENCY+2) cycles after start.
//  4. Timing: HASH_LATENCY=4 -> fills exactly 6 cycles apart; bloque_in[31:0] = 0,1,2,...
//     and stable between fills.
//  5. Ignored start / restart: start during WAIT -> no effect; start in FOUND -> found drops
//     next cycle, nonce restarts at 0.
//  6. Reset mid-WAIT at nonce 5 -> IDLE next edge, fill=0, no found, fresh start resumes at nonce 0.

Source files
------------

// File: rtl/nonce_search_ctrl_if.sv
// Bundle of the request, hash-core and result signals of the mining-loop controller.
// The controller takes the slave side; the host plus hash core take the master side.
interface nonce_search_ctrl_if;
  logic         start;
  logic [95:0]  header_in;
  logic [7:0]   target;
  logic [23:0]  hash_H;
  logic         fill;
  logic [127:0] bloque_in;
  logic         busy;
  logic         found;
  logic         exhausted;
  logic [31:0]  nonce_out;
  logic [23:0]  H_out;

  modport master (
    output start, header_in, target, hash_H,
    input  fill, bloque_in, busy, found, exhausted, nonce_out, H_out
  );

  modport slave (
    input  start, header_in, target, hash_H,
    output fill, bloque_in, busy, found, exhausted, nonce_out, H_out
  );
endinterface

// File: rtl/nonce_search_ctrl.sv
// Mining-loop controller: feeds {header, nonce} to micro_ucr_hash, waits its fixed
// latency, tests H against the target and steps the nonce until a hit or exhaustion.
module nonce_search_ctrl #(
  parameter int unsigned HASH_LATENCY = 20,
  parameter logic [31:0] MAX_NONCE    = 32'hFFFF_FFFF
) (
  input  logic                 clk,
  input  logic                 reset_L,
  nonce_search_ctrl_if.slave   bus
);

  localparam int unsigned CW = (HASH_LATENCY > 1) ? $clog2(HASH_LATENCY) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WAIT,
    S_CHECK,
    S_FOUND,
    S_EXHAUST
  } state_t;

  state_t        state;
  logic [95:0]   header_q;
  logic [7:0]    target_q;
  logic [31:0]   nonce;
  logic [CW-1:0] wait_cnt;
  logic          hit;

  assign hit = (bus.hash_H[23:16] < target_q) && (bus.hash_H[15:8] < target_q);

  always_ff @(posedge clk) begin
    if (!reset_L) begin
      state         <= S_IDLE;
      header_q      <= '0;
      target_q      <= '0;
      nonce         <= '0;
      wait_cnt      <= '0;
      bus.fill      <= 1'b0;
      bus.bloque_in <= '0;
      bus.busy      <= 1'b0;
      bus.found     <= 1'b0;
      bus.exhausted <= 1'b0;
      bus.nonce_out <= '0;
      bus.H_out     <= '0;
    end else begin
      case (state)
        // FOUND and EXHAUST accept a new request exactly like IDLE.
        S_IDLE, S_FOUND, S_EXHAUST: begin
          if (bus.start) begin
            header_q      <= bus.header_in;
            target_q      <= bus.target;
            nonce         <= '0;
            bus.bloque_in <= {bus.header_in, 32'h0};
            bus.fill      <= 1'b1;
            bus.busy      <= 1'b1;
            bus.found     <= 1'b0;
            bus.exhausted <= 1'b0;
            state         <= S_LOAD;
          end
        end
        S_LOAD: begin
          bus.fill <= 1'b0;
          wait_cnt <= CW'(HASH_LATENCY - 1);
          state    <= S_WAIT;
        end
        S_WAIT: begin
          if (wait_cnt == '0) begin
            state <= S_CHECK;
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end
        S_CHECK: begin
          if (hit) begin
            bus.nonce_out <= nonce;
            bus.H_out     <= bus.hash_H;
            bus.found     <= 1'b1;
            bus.busy      <= 1'b0;
            state         <= S_FOUND;
          end else if (nonce == MAX_NONCE) begin
            bus.exhausted <= 1'b1;
            bus.busy      <= 1'b0;
            state         <= S_EXHAUST;
          end else begin
            nonce         <= nonce + 32'd1;
            bus.bloque_in <= {header_q, nonce + 32'd1};
            bus.fill      <= 1'b1;
            state         <= S_LOAD;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nonce_search_ctrl.sv
// Bench for nonce_search_ctrl: a long-latency instance with the reference hash stub and a
// short-latency, small-range instance driven by random hash tables against a search model.
module tb_nonce_search_ctrl;

  localparam int unsigned LAT0 = 20;
  localparam int unsigned LAT1 = 4;
  localparam logic [31:0] MAX1 = 32'h0F;

  logic clk = 1'b0;
  logic rst0, rst1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  nonce_search_ctrl_if b0 ();
  nonce_search_ctrl_if b1 ();

  nonce_search_ctrl #(.HASH_LATENCY(LAT0)) dut0 (.clk(clk), .reset_L(rst0), .bus(b0));
  nonce_search_ctrl #(.HASH_LATENCY(LAT1), .MAX_NONCE(MAX1)) dut1 (.clk(clk), .reset_L(rst1), .bus(b1));

  // Hash stubs: H becomes valid LAT cycles after fill; zero (an easy hit) until then.
  bit [7:0]  s0_n;
  int        s0_cd = 1;
  always_ff @(posedge clk) begin
    if (b0.fill) begin
      s0_n  <= b0.bloque_in[7:0];
      s0_cd <= LAT0 - 1;
    end else if (s0_cd > 0) begin
      s0_cd <= s0_cd - 1;
    end
  end
  assign b0.hash_H = (s0_cd == 0) ? {8'hFF - s0_n, 8'hFF - s0_n, 8'h00} : 24'h0;

  bit [23:0] tbl [16];
  bit [3:0]  s1_i;
  int        s1_cd = 1;
  always_ff @(posedge clk) begin
    if (b1.fill) begin
      s1_i  <= b1.bloque_in[3:0];
      s1_cd <= LAT1 - 1;
    end else if (s1_cd > 0) begin
      s1_cd <= s1_cd - 1;
    end
  end
  assign b1.hash_H = (s1_cd == 0) ? tbl[s1_i] : 24'h0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // One search on dut1; expected outcome is the first table entry whose two upper bytes
  // are both below the target, searched in nonce order up to MAX1.
  task automatic run1(input logic [95:0] hdr, input logic [7:0] tgt);
    int exp_n, fills, cyc, last, gap_bad, seq_bad, stab_bad;
    logic [127:0] blk;
    exp_n = -1;
    for (int n = 0; n <= int'(MAX1); n++)
      if (exp_n < 0 && tbl[n][23:16] < tgt && tbl[n][15:8] < tgt) exp_n = n;
    b1.header_in = hdr;
    b1.target    = tgt;
    b1.start     = 1'b1;
    @(posedge clk); #1;
    b1.start = 1'b0;
    check("r1_start_fill", b1.fill, 1);
    check("r1_start_busy", b1.busy, 1);
    check("r1_start_clear", {b1.found, b1.exhausted}, 0);
    check("r1_first_blk", b1.bloque_in, {hdr, 32'h0});
    fills = 1; cyc = 0; last = 0; gap_bad = 0; seq_bad = 0; stab_bad = 0;
    blk = b1.bloque_in;
    while (!(b1.found || b1.exhausted) && cyc < 200) begin
      b1.header_in = {$urandom, $urandom, $urandom};
      b1.target    = 8'($urandom);
      b1.start     = ($urandom_range(0, 3) == 0);
      @(posedge clk); #1;
      cyc++;
      if (b1.fill) begin
        fills++;
        if (cyc - last != int'(LAT1) + 2) gap_bad++;
        if (b1.bloque_in !== {hdr, 32'(fills - 1)}) seq_bad++;
        last = cyc;
        blk  = b1.bloque_in;
      end else if (b1.bloque_in !== blk) begin
        stab_bad++;
      end
    end
    b1.start = 1'b0;
    check("r1_fill_gap", gap_bad, 0);
    check("r1_nonce_seq", seq_bad, 0);
    check("r1_blk_stable", stab_bad, 0);
    check("r1_busy_done", b1.busy, 0);
    if (exp_n >= 0) begin
      check("r1_found", {b1.found, b1.exhausted}, 2'b10);
      check("r1_nonce_out", b1.nonce_out, exp_n);
      check("r1_H_out", b1.H_out, tbl[exp_n]);
      check("r1_fills", fills, exp_n + 1);
      check("r1_cycles", cyc, (exp_n + 1) * (int'(LAT1) + 2));
    end else begin
      check("r1_exhausted", {b1.found, b1.exhausted}, 2'b01);
      check("r1_fills", fills, int'(MAX1) + 1);
      check("r1_cycles", cyc, (int'(MAX1) + 1) * (int'(LAT1) + 2));
    end
  endtask

  initial begin
    int fills, cyc, hdr_bad;
    rst0 = 1'b0; rst1 = 1'b0;
    b0.start = 1'b0; b0.header_in = '0; b0.target = '0;
    b1.start = 1'b0; b1.header_in = '0; b1.target = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_fill", {b0.fill, b1.fill}, 0);
    check("rst_blk0", b0.bloque_in, 0);
    check("rst_blk1", b1.bloque_in, 0);
    check("rst_flags", {b0.busy, b0.found, b0.exhausted, b1.busy, b1.found, b1.exhausted}, 0);
    check("rst_results", {b0.nonce_out, b0.H_out, b1.nonce_out, b1.H_out}, 0);
    rst0 = 1'b1; rst1 = 1'b1;
    @(posedge clk); #1;

    // Hit search on dut0 with an ignored start and input changes mid-WAIT.
    b0.header_in = 96'hA5; b0.target = 8'h10; b0.start = 1'b1;
    @(posedge clk); #1;
    b0.start = 1'b0;
    check("hit_first_blk", b0.bloque_in, {96'hA5, 32'h0});
    fills = 1; cyc = 0; hdr_bad = 0;
    while (!b0.found && !b0.exhausted && cyc < 6000) begin
      if (cyc == 30) begin
        b0.start = 1'b1; b0.header_in = 96'h123; b0.target = 8'hFF;
      end else begin
        b0.start = 1'b0;
      end
      @(posedge clk); #1;
      cyc++;
      if (b0.fill) begin
        fills++;
        if (b0.bloque_in[127:32] !== 96'hA5) hdr_bad++;
      end
    end
    check("hit_found", {b0.found, b0.exhausted, b0.busy}, 3'b100);
    check("hit_nonce_out", b0.nonce_out, 32'hF0);
    check("hit_H_out", b0.H_out, 24'h0F0F00);
    check("hit_fills", fills, 241);
    check("hit_cycles", cyc, 241 * (int'(LAT0) + 2));
    check("hit_hdr_held", hdr_bad, 0);

    // Restart from FOUND, then reset while waiting on nonce 5.
    b0.header_in = 96'h77; b0.target = 8'h10; b0.start = 1'b1;
    @(posedge clk); #1;
    b0.start = 1'b0;
    check("restart_found_drop", {b0.found, b0.busy, b0.fill}, 3'b011);
    check("restart_blk", b0.bloque_in, {96'h77, 32'h0});
    cyc = 0;
    while (!(b0.bloque_in[31:0] == 32'd5 && !b0.fill) && cyc < 300) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("reach_nonce5", b0.bloque_in[31:0], 5);
    rst0 = 1'b0;
    @(posedge clk); #1;
    rst0 = 1'b1;
    check("midrst_flags", {b0.fill, b0.busy, b0.found, b0.exhausted}, 0);
    check("midrst_blk", b0.bloque_in, 0);
    repeat (LAT0 + 4) @(posedge clk);
    #1;
    check("midrst_idle", {b0.fill, b0.busy, b0.found}, 0);
    b0.header_in = 96'hA5; b0.target = 8'h10; b0.start = 1'b1;
    @(posedge clk); #1;
    b0.start = 1'b0;
    check("fresh_blk", b0.bloque_in, {96'hA5, 32'h0});
    cyc = 0;
    while (!b0.found && !b0.exhausted && cyc < 6000) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("fresh_nonce_out", b0.nonce_out, 32'hF0);
    check("fresh_cycles", cyc, 241 * (int'(LAT0) + 2));

    // dut1: reference stub values (no hit below 0x10 within 16 nonces), then target 0.
    for (int n = 0; n < 16; n++) tbl[n] = {8'hFF - 8'(n), 8'hFF - 8'(n), 8'h00};
    run1(96'hA5, 8'h10);
    for (int n = 0; n < 16; n++) tbl[n] = 24'h0;
    run1(96'hBEEF, 8'h00);
    // Upper byte alone qualifies at nonce 2; both bytes only at nonce 9.
    for (int n = 0; n < 16; n++) tbl[n] = 24'hFFFF00;
    tbl[2] = 24'h05FF00;
    tbl[3] = 24'hFF0500;
    tbl[9] = 24'h0506AB;
    run1(96'hC0FFEE, 8'h20);
    for (int r = 0; r < 12; r++) begin
      for (int n = 0; n < 16; n++) tbl[n] = 24'($urandom);
      run1({$urandom, $urandom, $urandom}, 8'($urandom_range(0, 255)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
